idu_pipe: RTL and testbench



---
 rtl/idu_pipe.sv | 277 +++++++++++++++++++++++++++
 tb/tb_idu_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : idu_pipe
// Description : RV32I/RV64I instruction decode stage with valid/ready on both
//               sides. Decodes operand indices, sign-extended immediate, a
//               one-hot op class and ecall/ebreak/illegal flags, and registers
//               one result per accepted instruction. A flush input discards
//               every held entry.
// Build option: IDU_PIPE_SKID_EN - when defined, a 2-entry skid buffer with a
//               registered in_ready; otherwise a single output register with
//               in_ready = !out_valid || out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module idu_pipe #(
  parameter int XLEN = 32,
  parameter int OPW  = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_fun3,
  output logic [6:0]      out_fun7,
  output logic [XLEN-1:0] out_imm,
  output logic [OPW-1:0]  out_op_info,
  output logic            out_ebreak,
  output logic            out_ecall,
  output logic            out_illegal
);

  localparam bit c_RV64 = (XLEN == 64);

  // Major opcodes
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_ALU_I  = 7'b0010011;
  localparam logic [6:0] c_OPC_ALU_R  = 7'b0110011;
  localparam logic [6:0] c_OPC_ALU_IW = 7'b0011011;
  localparam logic [6:0] c_OPC_ALU_RW = 7'b0111011;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  // One-hot op class bit positions
  localparam int c_OP_LUI    = 0;
  localparam int c_OP_AUIPC  = 1;
  localparam int c_OP_JAL    = 2;
  localparam int c_OP_JALR   = 3;
  localparam int c_OP_BRANCH = 4;
  localparam int c_OP_LOAD   = 5;
  localparam int c_OP_STORE  = 6;
  localparam int c_OP_ALU_I  = 7;
  localparam int c_OP_ALU_R  = 8;
  localparam int c_OP_ALU_IW = 9;
  localparam int c_OP_ALU_RW = 10;
  localparam int c_OP_SYSTEM = 11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      fun3;
    logic [6:0]      fun7;
    logic [XLEN-1:0] imm;
    logic [OPW-1:0]  op;
    logic            eb;
    logic            ec;
    logic            ill;
  } beat_t;

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // --------------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic [2:0]      w_fun3;
  logic [6:0]      w_fun7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic            w_is_ecall;
  logic            w_is_ebreak;
  logic            w_load_ok;
  logic            w_store_ok;
  logic            w_fun7_ok;
  logic            w_branch_ok;
  logic [OPW-1:0]  w_op;
  logic [XLEN-1:0] w_imm;
  beat_t           w_dec;

  assign w_opcode = in_instr[6:0];
  assign w_fun3   = in_instr[14:12];
  assign w_fun7   = in_instr[31:25];

  // Signed size casts sign-extend from instr[31] for every format
  assign w_imm_i = XLEN'($signed(in_instr[31:20]));
  assign w_imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));

  assign w_is_ecall  = (in_instr == 32'h0000_0073);
  assign w_is_ebreak = (in_instr == 32'h0010_0073);

  assign w_branch_ok = !(w_fun3 inside {3'b010, 3'b011});
  assign w_load_ok   = (w_fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                       (c_RV64 && (w_fun3 inside {3'b011, 3'b110}));
  assign w_store_ok  = c_RV64 ? (w_fun3 <= 3'b011) : (w_fun3 <= 3'b010);
  assign w_fun7_ok   = (w_fun7 == 7'b0000000) || (w_fun7 == 7'b0100000);

  // Select op class and immediate; an encoding with no class is illegal
  always_comb begin
    w_op  = '0;
    w_imm = '0;
    case (w_opcode)
      c_OPC_LUI:    begin w_op[c_OP_LUI]   = 1'b1; w_imm = w_imm_u; end
      c_OPC_AUIPC:  begin w_op[c_OP_AUIPC] = 1'b1; w_imm = w_imm_u; end
      c_OPC_JAL:    begin w_op[c_OP_JAL]   = 1'b1; w_imm = w_imm_j; end
      c_OPC_JALR:   begin w_op[c_OP_JALR]  = 1'b1; w_imm = w_imm_i; end
      c_OPC_BRANCH: begin
        if (w_branch_ok) begin w_op[c_OP_BRANCH] = 1'b1; w_imm = w_imm_b; end
      end
      c_OPC_LOAD: begin
        if (w_load_ok) begin w_op[c_OP_LOAD] = 1'b1; w_imm = w_imm_i; end
      end
      c_OPC_STORE: begin
        if (w_store_ok) begin w_op[c_OP_STORE] = 1'b1; w_imm = w_imm_s; end
      end
      c_OPC_ALU_I:  begin w_op[c_OP_ALU_I] = 1'b1; w_imm = w_imm_i; end
      c_OPC_ALU_R: begin
        if (w_fun7_ok) w_op[c_OP_ALU_R] = 1'b1;
      end
      c_OPC_ALU_IW: begin
        if (c_RV64) begin w_op[c_OP_ALU_IW] = 1'b1; w_imm = w_imm_i; end
      end
      c_OPC_ALU_RW: begin
        if (c_RV64 && w_fun7_ok) w_op[c_OP_ALU_RW] = 1'b1;
      end
      c_OPC_SYSTEM: begin
        if (w_is_ecall || w_is_ebreak) w_op[c_OP_SYSTEM] = 1'b1;
      end
      default: ;
    endcase
  end

  // Pack the decoded beat that is captured on input transfer
  always_comb begin
    w_dec      = '0;
    w_dec.pc   = in_pc;
    w_dec.rs1  = in_instr[19:15];
    w_dec.rs2  = in_instr[24:20];
    w_dec.rd   = in_instr[11:7];
    w_dec.fun3 = w_fun3;
    w_dec.fun7 = w_fun7;
    w_dec.imm  = w_imm;
    w_dec.op   = w_op;
    w_dec.eb   = w_is_ebreak;
    w_dec.ec   = w_is_ecall;
    w_dec.ill  = ~|w_op;
  end

  // --------------------------------------------------------------------------
  // Holding storage; r_d0/r_v0 is always the entry presented downstream
  // --------------------------------------------------------------------------
  logic  r_v0;
  beat_t r_d0;
  logic  w_in_fire;
  logic  w_out_fire;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_v0 && out_ready && !flush;

`ifdef IDU_PIPE_SKID_EN
  logic       r_v1;
  beat_t      r_d1;
  logic       r_in_rdy;
  logic [1:0] w_cnt;
  logic [1:0] w_cnt_next;

  assign w_cnt      = {1'b0, r_v0} + {1'b0, r_v1};
  assign w_cnt_next = w_cnt - {1'b0, w_out_fire} + {1'b0, w_in_fire};

  // in_ready comes from a flop; rst/flush only gate it off
  assign in_ready = r_in_rdy && !rst && !flush;

  // Two-entry skid buffer: entry 1 absorbs a beat while entry 0 is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_d0     <= '0;
      r_d1     <= '0;
      r_in_rdy <= 1'b1;
    end else if (flush) begin
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_in_rdy <= 1'b1;
    end else begin
      if (w_out_fire) begin
        if (r_v1) begin
          r_d0 <= r_d1;
          r_v0 <= 1'b1;
          if (w_in_fire) begin
            r_d1 <= w_dec;
            r_v1 <= 1'b1;
          end else begin
            r_v1 <= 1'b0;
          end
        end else if (w_in_fire) begin
          r_d0 <= w_dec;
          r_v0 <= 1'b1;
        end else begin
          r_v0 <= 1'b0;
        end
      end else if (w_in_fire) begin
        if (!r_v0) begin
          r_d0 <= w_dec;
          r_v0 <= 1'b1;
        end else begin
          r_d1 <= w_dec;
          r_v1 <= 1'b1;
        end
      end
      r_in_rdy <= (w_cnt_next != 2'd2);
    end
  end
`else
  // A full register can still accept when the downstream drains it this cycle
  assign in_ready = !rst && !flush && (!r_v0 || out_ready);

  // Single output register: load on input transfer, empty on output transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_d0 <= '0;
    end else if (flush) begin
      r_v0 <= 1'b0;
    end else if (w_in_fire) begin
      r_v0 <= 1'b1;
      r_d0 <= w_dec;
    end else if (w_out_fire) begin
      r_v0 <= 1'b0;
    end
  end
`endif

  assign out_valid   = r_v0;
  assign out_pc      = r_d0.pc;
  assign out_rs1     = r_d0.rs1;
  assign out_rs2     = r_d0.rs2;
  assign out_rd      = r_d0.rd;
  assign out_fun3    = r_d0.fun3;
  assign out_fun7    = r_d0.fun7;
  assign out_imm     = r_d0.imm;
  assign out_op_info = r_d0.op;
  assign out_ebreak  = r_d0.eb;
  assign out_ecall   = r_d0.ec;
  assign out_illegal = r_d0.ill;

endmodule
`default_nettype wire

// File: tb/tb_idu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_idu_pipe
// Description : Self-checking bench for idu_pipe. Drives an XLEN=32 and an
//               XLEN=64 instance from the same stimulus and compares both
//               against a queue-based reference of held beats plus a
//               reference decoder built from the RISC-V encoding rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;

  logic        a_in_ready, a_out_valid, a_eb, a_ec, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [2:0]  a_f3;
  logic [6:0]  a_f7;
  logic [11:0] a_op;

  logic        b_in_ready, b_out_valid, b_eb, b_ec, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [2:0]  b_f3;
  logic [6:0]  b_f7;
  logic [11:0] b_op;

  idu_pipe #(.XLEN(32), .OPW(12)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc[31:0]), .in_instr(in_instr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_fun3(a_f3), .out_fun7(a_f7),
    .out_imm(a_imm), .out_op_info(a_op),
    .out_ebreak(a_eb), .out_ecall(a_ec), .out_illegal(a_ill)
  );

  idu_pipe #(.XLEN(64), .OPW(12)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_fun3(b_f3), .out_fun7(b_f7),
    .out_imm(b_imm), .out_op_info(b_op),
    .out_ebreak(b_eb), .out_ecall(b_ec), .out_illegal(b_ill)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } beat_t;

  typedef struct packed {
    logic [63:0] imm;
    logic [11:0] op;
    logic        ill;
    logic        ec;
    logic        eb;
  } dec_t;

  beat_t q[$];
  bit    just_reset;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = ~64'd0 << w;
    return v[w-1] ? (v | m) : (v & ~m);
  endfunction

  // Reference decoder: class number per opcode, -1 when the encoding is illegal
  function automatic dec_t ref_decode(input logic [31:0] ins, input bit rv64);
    dec_t       d;
    int         cls;
    int         fmt;   // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
    logic [2:0] f3;
    logic [6:0] f7;
    bit         f7ok;
    f3   = ins[14:12];
    f7   = ins[31:25];
    f7ok = (f7 == 7'h00) || (f7 == 7'h20);
    cls  = -1;
    fmt  = 0;
    case (ins[6:0])
      7'h37: begin cls = 0; fmt = 4; end
      7'h17: begin cls = 1; fmt = 4; end
      7'h6f: begin cls = 2; fmt = 5; end
      7'h67: begin cls = 3; fmt = 1; end
      7'h63: begin cls = (f3 == 3'd2 || f3 == 3'd3) ? -1 : 4; fmt = 3; end
      7'h03: begin
        cls = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5 ||
               (rv64 && (f3 == 3'd3 || f3 == 3'd6))) ? 5 : -1;
        fmt = 1;
      end
      7'h23: begin cls = (int'(f3) <= (rv64 ? 3 : 2)) ? 6 : -1; fmt = 2; end
      7'h13: begin cls = 7; fmt = 1; end
      7'h33: begin cls = f7ok ? 8 : -1; end
      7'h1b: begin cls = rv64 ? 9 : -1; fmt = 1; end
      7'h3b: begin cls = (rv64 && f7ok) ? 10 : -1; end
      7'h73: begin cls = (ins == 32'h73 || ins == 32'h0010_0073) ? 11 : -1; end
      default: cls = -1;
    endcase
    d.ec = (ins == 32'h0000_0073);
    d.eb = (ins == 32'h0010_0073);
    if (cls < 0) begin
      d.op  = '0;
      d.ill = 1'b1;
      d.imm = '0;
    end else begin
      d.op  = 12'd1 << cls;
      d.ill = 1'b0;
      case (fmt)
        1: d.imm = sext(64'(ins[31:20]), 12);
        2: d.imm = sext(64'({ins[31:25], ins[11:7]}), 12);
        3: d.imm = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
        4: d.imm = sext(64'({ins[31:12], 12'h000}), 32);
        5: d.imm = sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
        default: d.imm = '0;
      endcase
      if (!rv64) d.imm = d.imm & 64'hffff_ffff;
    end
    return d;
  endfunction

  task automatic chk_side(input string s, input bit rv64, input bit exp_rdy,
                          input logic rdy, input logic vld, input logic [63:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm,
                          input logic [11:0] op, input logic eb, input logic ec, input logic ill);
    dec_t        d;
    logic [63:0] epc;
    logic [31:0] ins;
    chk({s, ".in_ready"}, 64'(rdy), 64'(exp_rdy));
    chk({s, ".out_valid"}, 64'(vld), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ins = q[0].instr;
      d   = ref_decode(ins, rv64);
      epc = rv64 ? q[0].pc : {32'd0, q[0].pc[31:0]};
      chk({s, ".pc"}, pc, epc);
      chk({s, ".regs"}, 64'({rs1, rs2, rd}), 64'({ins[19:15], ins[24:20], ins[11:7]}));
      chk({s, ".fun"}, 64'({f3, f7}), 64'({ins[14:12], ins[31:25]}));
      chk({s, ".imm"}, imm, d.imm);
      chk({s, ".op_info"}, 64'(op), 64'(d.op));
      chk({s, ".flags"}, 64'({eb, ec, ill}), 64'({d.eb, d.ec, d.ill}));
    end else if (just_reset) begin
      chk({s, ".rst_pc"}, pc, 64'd0);
      chk({s, ".rst_imm"}, imm, 64'd0);
      chk({s, ".rst_fields"}, 64'({rs1, rs2, rd, f3, f7, op, eb, ec, ill}), 64'd0);
    end
  endtask

  // One clock: drive after the falling edge, check, then advance the model
  task automatic cycle(input bit r, input bit f, input bit iv, input logic [63:0] pc,
                       input logic [31:0] ins, input bit ordy, output bit acc);
    bit    exp_rdy;
    beat_t b;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    #1;
`ifdef IDU_PIPE_SKID_EN
    exp_rdy = !r && !f && (q.size() < 2);
`else
    exp_rdy = !r && !f && (q.size() == 0 || ordy);
`endif
    chk_side("x32", 1'b0, exp_rdy, a_in_ready, a_out_valid, {32'd0, a_pc},
             a_rs1, a_rs2, a_rd, a_f3, a_f7, {32'd0, a_imm}, a_op, a_eb, a_ec, a_ill);
    chk_side("x64", 1'b1, exp_rdy, b_in_ready, b_out_valid, b_pc,
             b_rs1, b_rs2, b_rd, b_f3, b_f7, b_imm, b_op, b_eb, b_ec, b_ill);
    acc = iv && exp_rdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (f) begin
        q.delete();
      end else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (acc) begin
          b.pc    = pc;
          b.instr = ins;
          q.push_back(b);
        end
      end
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  opcs [12] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                               7'h23, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h73};
    logic [31:0] v;
    int          sel;
    sel = int'($urandom_range(0, 9));
    v   = $urandom;
    if (sel == 0) return 32'h0000_0073;
    if (sel == 1) return 32'h0010_0073;
    if (sel == 2) return v;
    v[6:0] = opcs[$urandom_range(0, 11)];
    if ($urandom_range(0, 1) == 0) v[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    return v;
  endfunction

  initial begin
    logic [31:0] dir [6] = '{32'hfff0_0093, 32'h0080_006f, 32'h0010_0073,
                             32'h0000_0073, 32'h0000_0000, 32'h0010_009b};
    bit acc;
    int sent;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    just_reset = 1'b1;

    // Directed decode stream with the consumer always ready
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b0, 1'b1, 64'h8000_0000 + 64'(i * 4), dir[i], 1'b1, acc);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1, acc);

    // Eight sequential beats with a three-cycle stall in the middle
    sent = 0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      cycle(1'b0, 1'b0, 1'b1, 64'h1000 + 64'(sent * 4),
            32'h0000_0013 | (32'(sent) << 20) | (32'(sent) << 7), !(c >= 3 && c < 6), acc);
      if (acc) sent++;
    end
    chk("bp.sent", 64'(sent), 64'd8);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1, acc);

    // Fill the holding storage, then flush while a new beat is offered
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 1'b0, 1'b1, 64'h2000 + 64'(k * 4), 32'h0010_0113, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b1, 64'h3000, 32'h0050_0113, 1'b1, acc);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1, acc);

    // Reset while a beat is stalled at the output
    cycle(1'b0, 1'b0, 1'b1, 64'h4000, 32'h0000_0093, 1'b0, acc);
    cycle(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b1, 64'h4004, 32'h0000_0113, 1'b0, acc);
    cycle(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, acc);
    cycle(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1, acc);

    // Random traffic, backpressure, flushes and resets
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 70,
            {$urandom, $urandom}, rnd_instr(), $urandom_range(0, 99) < 70, acc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
